// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg: shared AES-128 constants, GF(2^8) helpers and S-box tables.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_XOR  = 2'd2,
    ST_DONE = 2'd3
  } key_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1B;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Coefficients used by (Inv)MixColumns all fit in four bits.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [2047:0] t;
    logic [2047:0] s;
    t = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    s = t >> {8'hFF - b, 3'b000};
    return s[7:0];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [2047:0] t;
    logic [2047:0] s;
    t = {128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
         128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
         128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
         128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
         128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
         128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
         128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
         128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
    s = t >> {8'hFF - b, 3'b000};
    return s[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_units_if.sv
// ============================================================================
// aes_round_units_if: operand/result bundle between the AES controller and
// the round units. The inv signal exists only when AES_INV_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface aes_round_units_if;
  import aes_pkg::*;

`ifdef AES_INV_EN
  logic                  inv;
`endif
  logic [BYTE_W-1:0]     sb_in;
  logic [BYTE_W-1:0]     sb_out;
  logic [WORD_W-1:0]     mc_in;
  logic [WORD_W-1:0]     mc_out;
  logic [BLOCK_W-1:0]    key_in;
  logic                  key_load;
  logic                  key_next;
  logic [BLOCK_W-1:0]    round_key_o;
  logic [3:0]            key_round;
  logic                  key_busy;
  logic                  key_valid;

  modport master (
`ifdef AES_INV_EN
    output inv,
`endif
    output sb_in, mc_in, key_in, key_load, key_next,
    input  sb_out, mc_out, round_key_o, key_round, key_busy, key_valid
  );

  modport slave (
`ifdef AES_INV_EN
    input  inv,
`endif
    input  sb_in, mc_in, key_in, key_load, key_next,
    output sb_out, mc_out, round_key_o, key_round, key_busy, key_valid
  );

endinterface

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox: combinational byte substitution; inverse table selectable by inv
// when AES_INV_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
`ifdef AES_INV_EN
  input  wire logic       inv,
`endif
  input  wire logic [7:0] in_byte,
  output logic      [7:0] out_byte
);

`ifdef AES_INV_EN
  assign out_byte = inv ? sbox_inv(in_byte) : sbox_fwd(in_byte);
`else
  assign out_byte = sbox_fwd(in_byte);
`endif

endmodule

`default_nettype wire

// File: rtl/aes_round_units.sv
// ============================================================================
// aes_round_units: S-box, MixColumns and iterative AES-128 round-key generator.
// Optional AES_INV_EN adds inverse S-box / InvMixColumns on the data path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_round_units
  import aes_pkg::*;
#(
  parameter int KEY_STEP_CYCLES = 6
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  aes_round_units_if.slave  bus
);

  localparam logic [1:0] LAST_SUB = 2'(KEY_STEP_CYCLES - 3);

  key_state_e          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   temp_q, temp_d;
  logic [BLOCK_W-1:0]  round_key_q, round_key_d;
  logic [3:0]          round_q, round_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;

  logic [1:0]          sub_idx;
  logic [7:0]          key_sb_in;
  logic [7:0]          key_sb_out;
  logic [WORD_W-1:0]   w0, w1, w2, w3, w0n, w1n, w2n, w3n;
  logic [15:0]         mc_coefs;
  logic [WORD_W-1:0]   mc_res;
  logic [7:0]          mc_acc;

  // Data-path S-box.
  aes_sbox u_sbox_data (
`ifdef AES_INV_EN
    .inv      (bus.inv),
`endif
    .in_byte  (bus.sb_in),
    .out_byte (bus.sb_out)
  );

  // Key-expansion S-box is always forward.
  aes_sbox u_sbox_key (
`ifdef AES_INV_EN
    .inv      (1'b0),
`endif
    .in_byte  (key_sb_in),
    .out_byte (key_sb_out)
  );

`ifdef AES_INV_EN
  assign mc_coefs = bus.inv ? 16'hEBD9 : 16'h2311;
`else
  assign mc_coefs = 16'h2311;
`endif

  // Row i of the output uses coefficient (j - i) mod 4 for input row j.
  always_comb begin
    mc_res = '0;
    for (int i = 0; i < 4; i++) begin
      mc_acc = 8'h00;
      for (int j = 0; j < 4; j++) begin
        mc_acc = mc_acc ^ gmul(bus.mc_in[31 - 8*j -: 8], mc_coefs[15 - 4*((j - i + 4) % 4) -: 4]);
      end
      mc_res[31 - 8*i -: 8] = mc_acc;
    end
  end
  assign bus.mc_out = mc_res;

  assign sub_idx   = 2'd3 - cnt_q;
  assign key_sb_in = temp_q[{sub_idx, 3'b000} +: 8];

  assign {w0, w1, w2, w3} = round_key_q;
  assign w0n = w0 ^ temp_q;
  assign w1n = w1 ^ w0n;
  assign w2n = w2 ^ w1n;
  assign w3n = w3 ^ w2n;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    temp_d      = temp_q;
    round_key_d = round_key_q;
    round_d     = round_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    if (bus.key_load) begin
      round_key_d = bus.key_in;
      round_d     = 4'd0;
      busy_d      = 1'b0;
      valid_d     = 1'b1;
      cnt_d       = 2'd0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The key_valid cycle still counts as not idle for new requests.
          if (bus.key_next && !valid_q && (round_q < 4'd10)) begin
            busy_d  = 1'b1;
            temp_d  = {w3[23:0], w3[31:24]};
            cnt_d   = 2'd0;
            state_d = ST_SUB;
          end
        end
        ST_SUB: begin
          temp_d[{sub_idx, 3'b000} +: 8] = key_sb_out;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_SUB) state_d = ST_XOR;
        end
        ST_XOR: begin
          temp_d  = temp_q ^ {rcon(round_q + 4'd1), 24'h000000};
          state_d = ST_DONE;
        end
        ST_DONE: begin
          round_key_d = {w0n, w1n, w2n, w3n};
          round_d     = round_q + 4'd1;
          valid_d     = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      temp_q      <= '0;
      round_key_q <= '0;
      round_q     <= 4'd0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      temp_q      <= temp_d;
      round_key_q <= round_key_d;
      round_q     <= round_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.round_key_o = round_key_q;
  assign bus.key_round   = round_q;
  assign bus.key_busy    = busy_q;
  assign bus.key_valid   = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_units.sv
// ============================================================================
// tb_aes_round_units: directed vectors for the S-box, MixColumns and the
// round-key generator (FIPS-197 appendix A.1 key schedule).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_round_units;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  aes_round_units_if bus();

  aes_round_units #(.KEY_STEP_CYCLES(6)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  sb_in;
    logic [7:0]  sb_exp;
    logic [31:0] mc_in;
    logic [31:0] mc_exp;
  } comb_vec_t;

  comb_vec_t    cv [5];
  logic [127:0] rk [11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(inout int cyc);
    while (!bus.key_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_quiet(input string name, input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.key_valid) seen++;
    end
    chk(name, 128'(seen), 128'd0);
  endtask

  task automatic do_load(input string name);
    @(negedge clk);
    bus.key_in   = KEY;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    chk({name, " key"},   bus.round_key_o, KEY);
    chk({name, " round"}, 128'(bus.key_round), 128'd0);
    chk({name, " valid"}, 128'(bus.key_valid), 128'd1);
  endtask

  task automatic do_step(input string name, input logic [127:0] exp_key, input logic [3:0] exp_round);
    int cyc;
    @(negedge clk);
    bus.key_next = 1'b1;
    @(negedge clk);
    bus.key_next = 1'b0;
    cyc = 0;
    chk({name, " busy"}, 128'(bus.key_busy), 128'd1);
    wait_valid(cyc);
    chk({name, " latency"}, 128'(cyc), 128'd6);
    chk({name, " key"},     bus.round_key_o, exp_key);
    chk({name, " round"},   128'(bus.key_round), 128'(exp_round));
  endtask

  initial begin
    int cyc;

    cv[0] = '{8'h00, 8'h63, 32'hDB135345, 32'h8E4DA1BC};
    cv[1] = '{8'h01, 8'h7C, 32'hF20A225C, 32'h9FDC589D};
    cv[2] = '{8'h53, 8'hED, 32'h01010101, 32'h01010101};
    cv[3] = '{8'hFF, 8'h16, 32'hC6C6C6C6, 32'hC6C6C6C6};
    cv[4] = '{8'h10, 8'hCA, 32'h2D26314C, 32'h4D7EBDF8};

    rk[0]  = KEY;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

`ifdef AES_INV_EN
    bus.inv = 1'b0;
`endif
    bus.sb_in    = 8'h00;
    bus.mc_in    = 32'h0;
    bus.key_in   = 128'h0;
    bus.key_load = 1'b0;
    bus.key_next = 1'b0;

    #1 rst_n = 1'b0;
    #3;
    chk("reset round_key", bus.round_key_o, 128'h0);
    chk("reset round",     128'(bus.key_round), 128'd0);
    chk("reset busy",      128'(bus.key_busy), 128'd0);
    chk("reset valid",     128'(bus.key_valid), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      bus.sb_in = cv[i].sb_in;
      bus.mc_in = cv[i].mc_in;
      #1;
      chk($sformatf("sbox[%0d]", i), 128'(bus.sb_out), 128'(cv[i].sb_exp));
      chk($sformatf("mixcol[%0d]", i), 128'(bus.mc_out), 128'(cv[i].mc_exp));
    end

`ifdef AES_INV_EN
    bus.inv   = 1'b1;
    bus.sb_in = 8'h63;
    bus.mc_in = 32'h8E4DA1BC;
    #1;
    chk("inv sbox 63",   128'(bus.sb_out), 128'h00);
    chk("inv mixcol",    128'(bus.mc_out), 128'hDB135345);
    bus.sb_in = 8'hED;
    #1;
    chk("inv sbox ED",   128'(bus.sb_out), 128'h53);
    bus.inv = 1'b0;
`endif

    // Full schedule, including the ignored request after round 10.
    do_load("load");
    for (int r = 1; r <= 10; r++) do_step($sformatf("step%0d", r), rk[r], 4'(r));
    @(negedge clk);
    bus.key_next = 1'b1;
    @(negedge clk);
    bus.key_next = 1'b0;
    count_quiet("step11 no valid", 10);
    chk("step11 key",   bus.round_key_o, rk[10]);
    chk("step11 round", 128'(bus.key_round), 128'd10);

    // key_next while busy, then key_next coincident with key_valid.
    do_load("reload");
    @(negedge clk);
    bus.key_next = 1'b1;
    @(negedge clk);
    bus.key_next = 1'b0;
    cyc = 0;
    repeat (2) begin @(negedge clk); cyc++; end
    bus.key_next = 1'b1;
    @(negedge clk);
    cyc++;
    bus.key_next = 1'b0;
    wait_valid(cyc);
    chk("busy-next latency", 128'(cyc), 128'd6);
    chk("busy-next key",     bus.round_key_o, rk[1]);
    bus.key_next = 1'b1;
    @(negedge clk);
    bus.key_next = 1'b0;
    count_quiet("next-on-valid no valid", 10);
    chk("next-on-valid round", 128'(bus.key_round), 128'd1);

    // key_load three cycles into a step aborts it.
    @(negedge clk);
    bus.key_next = 1'b1;
    @(negedge clk);
    bus.key_next = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy before", 128'(bus.key_busy), 128'd1);
    bus.key_in   = KEY;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    chk("abort key",   bus.round_key_o, KEY);
    chk("abort round", 128'(bus.key_round), 128'd0);
    chk("abort busy",  128'(bus.key_busy), 128'd0);
    count_quiet("abort no valid", 8);
    chk("abort key held", bus.round_key_o, KEY);

    // Asynchronous reset in the middle of a step.
    @(negedge clk);
    bus.key_next = 1'b1;
    @(negedge clk);
    bus.key_next = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset round_key", bus.round_key_o, 128'h0);
    chk("midreset round",     128'(bus.key_round), 128'd0);
    chk("midreset busy",      128'(bus.key_busy), 128'd0);
    chk("midreset valid",     128'(bus.key_valid), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load("post-reset load");
    do_step("post-reset step", rk[1], 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
